// File: rtl/machine_csr_file.sv
// Machine-mode CSR register file for the RV32I core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval/mip and the 64-bit
// mcycle/minstret counters. Trap strobes from the trap/return FSM take
// priority over a same-cycle Zicsr write to the same register.
module machine_csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  zimm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] fault_addr_in,
    input  logic        set_epc_in,
    input  logic        set_cause_in,
    input  logic        i_or_e_in,
    input  logic [3:0]  cause_in,
    input  logic        misaligned_exception_in,
    input  logic        instret_inc_in,
    input  logic        mie_clear_in,
    input  logic        mie_set_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    output logic [31:0] csr_data_out,
    output logic        mie_out,
    output logic        meie_out,
    output logic        mtie_out,
    output logic        msie_out,
    output logic        meip_out,
    output logic        mtip_out,
    output logic        msip_out,
    output logic [31:0] trap_address_out,
    output logic [31:0] epc_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    logic        status_mie;
    logic        status_mpie;
    logic        msie;
    logic        mtie;
    logic        meie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic        mcause_int;
    logic [3:0]  mcause_code;
    logic [31:0] mtval;
    logic        meip;
    logic        mtip;
    logic        msip;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] read_data;
    logic [31:0] operand;
    logic [31:0] write_data;
    logic [31:0] trap_base;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
    logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;

    // Combinational read mux; unmapped addresses (including F11-F14) read zero.
    always_comb begin
        read_data = 32'h0;
        case (csr_addr_in)
            ADDR_MSTATUS:   read_data = {19'h0, 2'b11, 3'h0, status_mpie, 3'h0, status_mie, 3'h0};
            ADDR_MISA:      read_data = MISA_VALUE;
            ADDR_MIE:       read_data = {20'h0, meie, 3'h0, mtie, 3'h0, msie, 3'h0};
            ADDR_MTVEC:     read_data = mtvec;
            ADDR_MSCRATCH:  read_data = mscratch;
            ADDR_MEPC:      read_data = mepc;
            ADDR_MCAUSE:    read_data = {mcause_int, 27'h0, mcause_code};
            ADDR_MTVAL:     read_data = mtval;
            ADDR_MIP:       read_data = {20'h0, meip, 3'h0, mtip, 3'h0, msip, 3'h0};
            ADDR_MCYCLE:    read_data = mcycle[31:0];
            ADDR_MCYCLEH:   read_data = mcycle[63:32];
            ADDR_MINSTRET:  read_data = minstret[31:0];
            ADDR_MINSTRETH: read_data = minstret[63:32];
            default:        read_data = 32'h0;
        endcase
    end

    // Write data from funct3: bit2 selects the zero-extended immediate, bits[1:0] the op.
    always_comb begin
        operand    = csr_op_in[2] ? {27'h0, zimm_in} : rs1_in;
        write_data = read_data;
        case (csr_op_in[1:0])
            2'b01:   write_data = operand;
            2'b10:   write_data = read_data | operand;
            2'b11:   write_data = read_data & ~operand;
            default: write_data = read_data;
        endcase
    end

    // Per-register write strobes; read-only and unmapped addresses have none.
    always_comb begin
        wr_mstatus     = csr_wr_en_in && (csr_addr_in == ADDR_MSTATUS);
        wr_mie         = csr_wr_en_in && (csr_addr_in == ADDR_MIE);
        wr_mtvec       = csr_wr_en_in && (csr_addr_in == ADDR_MTVEC);
        wr_mscratch    = csr_wr_en_in && (csr_addr_in == ADDR_MSCRATCH);
        wr_mepc        = csr_wr_en_in && (csr_addr_in == ADDR_MEPC);
        wr_mcause      = csr_wr_en_in && (csr_addr_in == ADDR_MCAUSE);
        wr_mtval       = csr_wr_en_in && (csr_addr_in == ADDR_MTVAL);
        wr_mcycle_lo   = csr_wr_en_in && (csr_addr_in == ADDR_MCYCLE);
        wr_mcycle_hi   = csr_wr_en_in && (csr_addr_in == ADDR_MCYCLEH);
        wr_minstret_lo = csr_wr_en_in && (csr_addr_in == ADDR_MINSTRET);
        wr_minstret_hi = csr_wr_en_in && (csr_addr_in == ADDR_MINSTRETH);
    end

    // Status/trap registers; hardware strobes beat a software write to the same register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            msie        <= 1'b0;
            mtie        <= 1'b0;
            meie        <= 1'b0;
            mtvec       <= RESET_MTVEC & ~32'h2;
            mscratch    <= 32'h0;
            mepc        <= 32'h0;
            mcause_int  <= 1'b0;
            mcause_code <= 4'h0;
            mtval       <= 32'h0;
        end else begin
            if (mie_clear_in) begin
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mie_set_in) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end else if (wr_mstatus) begin
                status_mie  <= write_data[3];
                status_mpie <= write_data[7];
            end
            if (wr_mie) begin
                msie <= write_data[3];
                mtie <= write_data[7];
                meie <= write_data[11];
            end
            if (wr_mtvec)
                mtvec <= write_data & ~32'h2;
            if (wr_mscratch)
                mscratch <= write_data;
            if (set_epc_in)
                mepc <= pc_in & ~32'h3;
            else if (wr_mepc)
                mepc <= write_data & ~32'h3;
            if (set_cause_in) begin
                mcause_int  <= i_or_e_in;
                mcause_code <= cause_in;
                mtval       <= misaligned_exception_in ? fault_addr_in : 32'h0;
            end else begin
                if (wr_mcause) begin
                    mcause_int  <= write_data[31];
                    mcause_code <= write_data[3:0];
                end
                if (wr_mtval)
                    mtval <= write_data;
            end
        end
    end

    // Pending bits are one-cycle registered copies of the raw interrupt lines.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            meip <= 1'b0;
            mtip <= 1'b0;
            msip <= 1'b0;
        end else begin
            meip <= e_irq_in;
            mtip <= t_irq_in;
            msip <= s_irq_in;
        end
    end

    // 64-bit counters; a write to either half replaces it and skips that cycle's increment.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mcycle   <= 64'h0;
            minstret <= 64'h0;
        end else begin
            if (wr_mcycle_lo)
                mcycle[31:0] <= write_data;
            else if (wr_mcycle_hi)
                mcycle[63:32] <= write_data;
            else
                mcycle <= mcycle + 64'h1;
            if (wr_minstret_lo)
                minstret[31:0] <= write_data;
            else if (wr_minstret_hi)
                minstret[63:32] <= write_data;
            else if (instret_inc_in)
                minstret <= minstret + 64'h1;
        end
    end

    // Trap target: vectored mode offsets interrupts by 4*cause from the base.
    always_comb begin
        trap_base        = {mtvec[31:2], 2'b00};
        trap_address_out = trap_base;
        if ((mtvec[1:0] == 2'b01) && mcause_int)
            trap_address_out = trap_base + {26'h0, mcause_code, 2'b00};
    end

    assign csr_data_out = read_data;
    assign epc_out      = mepc;
    assign mie_out      = status_mie;
    assign meie_out     = meie;
    assign mtie_out     = mtie;
    assign msie_out     = msie;
    assign meip_out     = meip;
    assign mtip_out     = mtip;
    assign msip_out     = msip;

endmodule

// File: tb/tb_machine_csr_file.sv
// Testbench for machine_csr_file: random CSR traffic and trap strobes checked
// against a behavioural model, plus directed trap/return and counter scenarios.
module tb_machine_csr_file;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic        csr_wr_en_in;
    logic [31:0] rs1_in;
    logic [4:0]  zimm_in;
    logic [31:0] pc_in;
    logic [31:0] fault_addr_in;
    logic        set_epc_in, set_cause_in, i_or_e_in;
    logic [3:0]  cause_in;
    logic        misaligned_exception_in;
    logic        instret_inc_in, mie_clear_in, mie_set_in;
    logic        e_irq_in, t_irq_in, s_irq_in;
    logic [31:0] csr_data_out;
    logic        mie_out, meie_out, mtie_out, msie_out;
    logic        meip_out, mtip_out, msip_out;
    logic [31:0] trap_address_out;
    logic [31:0] epc_out;

    machine_csr_file dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .csr_addr_in(csr_addr_in), .csr_op_in(csr_op_in), .csr_wr_en_in(csr_wr_en_in),
        .rs1_in(rs1_in), .zimm_in(zimm_in), .pc_in(pc_in), .fault_addr_in(fault_addr_in),
        .set_epc_in(set_epc_in), .set_cause_in(set_cause_in), .i_or_e_in(i_or_e_in),
        .cause_in(cause_in), .misaligned_exception_in(misaligned_exception_in),
        .instret_inc_in(instret_inc_in), .mie_clear_in(mie_clear_in), .mie_set_in(mie_set_in),
        .e_irq_in(e_irq_in), .t_irq_in(t_irq_in), .s_irq_in(s_irq_in),
        .csr_data_out(csr_data_out),
        .mie_out(mie_out), .meie_out(meie_out), .mtie_out(mtie_out), .msie_out(msie_out),
        .meip_out(meip_out), .mtip_out(mtip_out), .msip_out(msip_out),
        .trap_address_out(trap_address_out), .epc_out(epc_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, kept as architectural fields rather than raw register images.
    logic        m_mie, m_mpie, m_msie, m_mtie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mtval;
    logic        m_iore;
    logic [3:0]  m_cause;
    logic        m_meip, m_mtip, m_msip;
    bit   [63:0] m_cycle, m_instret;

    logic [11:0] addr_list [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                    12'hB82, 12'hF11, 12'hF14, 12'h7C0, 12'h000};
    logic [2:0]  op_list [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == 12'h300) v = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
        if (a == 12'h301) v = 32'h4000_0100;
        if (a == 12'h304) v = (m_meie ? 32'h800 : 0) + (m_mtie ? 32'h80 : 0) + (m_msie ? 32'h8 : 0);
        if (a == 12'h305) v = m_mtvec;
        if (a == 12'h340) v = m_mscratch;
        if (a == 12'h341) v = m_mepc;
        if (a == 12'h342) v = (m_iore ? 32'h8000_0000 : 0) + 32'(m_cause);
        if (a == 12'h343) v = m_mtval;
        if (a == 12'h344) v = (m_meip ? 32'h800 : 0) + (m_mtip ? 32'h80 : 0) + (m_msip ? 32'h8 : 0);
        if (a == 12'hB00) v = m_cycle[31:0];
        if (a == 12'hB80) v = m_cycle[63:32];
        if (a == 12'hB02) v = m_instret[31:0];
        if (a == 12'hB82) v = m_instret[63:32];
        return v;
    endfunction

    function automatic logic [31:0] model_trap();
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
        if ((m_mtvec % 4) == 1 && m_iore) return base + 32'(m_cause) * 4;
        return base;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_msie = 0; m_mtie = 0; m_meie = 0;
        m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mtval = 0;
        m_iore = 0; m_cause = 0; m_meip = 0; m_mtip = 0; m_msip = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    // Apply one clock edge worth of architectural effects to the model.
    task automatic model_update();
        logic [31:0] old, opnd, w;
        logic        sw;
        logic        old_mie, old_mpie;
        old  = model_read(csr_addr_in);
        opnd = (csr_op_in >= 3'b101) ? {27'h0, zimm_in} : rs1_in;
        case (csr_op_in)
            3'b001, 3'b101: w = opnd;
            3'b010, 3'b110: w = old | opnd;
            3'b011, 3'b111: w = old & ~opnd;
            default:        w = old;
        endcase
        sw = csr_wr_en_in;
        old_mie = m_mie; old_mpie = m_mpie;
        if (mie_clear_in) begin
            m_mpie = old_mie; m_mie = 0;
        end else if (mie_set_in) begin
            m_mie = old_mpie; m_mpie = 1;
        end else if (sw && csr_addr_in == 12'h300) begin
            m_mie = w[3]; m_mpie = w[7];
        end
        if (sw && csr_addr_in == 12'h304) begin
            m_msie = w[3]; m_mtie = w[7]; m_meie = w[11];
        end
        if (sw && csr_addr_in == 12'h305) m_mtvec = w & ~32'h2;
        if (sw && csr_addr_in == 12'h340) m_mscratch = w;
        if (set_epc_in) m_mepc = pc_in & ~32'h3;
        else if (sw && csr_addr_in == 12'h341) m_mepc = w & ~32'h3;
        if (set_cause_in) begin
            m_iore  = i_or_e_in;
            m_cause = cause_in;
            m_mtval = misaligned_exception_in ? fault_addr_in : 32'h0;
        end else begin
            if (sw && csr_addr_in == 12'h342) begin
                m_iore = w[31]; m_cause = w[3:0];
            end
            if (sw && csr_addr_in == 12'h343) m_mtval = w;
        end
        if (sw && csr_addr_in == 12'hB00)      m_cycle = {m_cycle[63:32], w};
        else if (sw && csr_addr_in == 12'hB80) m_cycle = {w, m_cycle[31:0]};
        else                                   m_cycle = m_cycle + 1;
        if (sw && csr_addr_in == 12'hB02)      m_instret = {m_instret[63:32], w};
        else if (sw && csr_addr_in == 12'hB82) m_instret = {w, m_instret[31:0]};
        else if (instret_inc_in)               m_instret = m_instret + 1;
        m_meip = e_irq_in; m_mtip = t_irq_in; m_msip = s_irq_in;
    endtask

    task automatic idle_inputs();
        csr_addr_in = 12'h0; csr_op_in = 3'b000; csr_wr_en_in = 0;
        rs1_in = 0; zimm_in = 0; pc_in = 0; fault_addr_in = 0;
        set_epc_in = 0; set_cause_in = 0; i_or_e_in = 0; cause_in = 0;
        misaligned_exception_in = 0; instret_inc_in = 0; mie_clear_in = 0; mie_set_in = 0;
        e_irq_in = 0; t_irq_in = 0; s_irq_in = 0;
    endtask

    // One clock: check the pre-edge read, clock, then check all state-derived outputs.
    task automatic step(input string tag);
        #1;
        check_val({tag, "_rd"}, csr_data_out, model_read(csr_addr_in));
        @(posedge clk_in);
        model_update();
        #1;
        check_val({tag, "_flags"},
                  {25'h0, mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out},
                  {25'h0, m_mie, m_meie, m_mtie, m_msie, m_meip, m_mtip, m_msip});
        check_val({tag, "_trap"}, trap_address_out, model_trap());
        check_val({tag, "_epc"}, epc_out, m_mepc);
    endtask

    task automatic peek(input logic [11:0] a, input string tag, input logic [31:0] exp);
        csr_addr_in = a; csr_wr_en_in = 0;
        #1;
        check_val(tag, csr_data_out, exp);
    endtask

    task automatic random_cycle();
        csr_addr_in  = addr_list[$urandom_range(16)];
        csr_op_in    = op_list[$urandom_range(5)];
        csr_wr_en_in = ($urandom_range(1) == 1);
        rs1_in       = $urandom;
        zimm_in      = 5'($urandom);
        pc_in        = $urandom;
        fault_addr_in = $urandom;
        set_epc_in   = ($urandom_range(7) == 0);
        set_cause_in = ($urandom_range(7) == 0);
        i_or_e_in    = 1'($urandom);
        cause_in     = 4'($urandom);
        misaligned_exception_in = 1'($urandom);
        instret_inc_in = 1'($urandom);
        mie_clear_in = ($urandom_range(7) == 0);
        mie_set_in   = ($urandom_range(7) == 0);
        e_irq_in = 1'($urandom); t_irq_in = 1'($urandom); s_irq_in = 1'($urandom);
        step("rnd");
    endtask

    initial begin
        idle_inputs();
        reset_in = 1;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 0;
        peek(12'h300, "por_mstatus", 32'h1800);
        peek(12'h305, "por_mtvec", 32'h0);

        repeat (300) random_cycle();

        // Reset mid-count, released between edges.
        idle_inputs();
        reset_in = 1;
        #2;
        model_reset();
        check_val("rst_trap", trap_address_out, 32'h0);
        reset_in = 0;
        peek(12'h300, "rst_mstatus", 32'h1800);
        peek(12'h305, "rst_mtvec", 32'h0);
        peek(12'hB00, "rst_mcycle", 32'h0);
        step("rst_run");
        peek(12'hB00, "rst_mcycle_next", 32'h1);

        // CSRRW sets MIE, CSRRCI clears it and reads the pre-write value.
        csr_addr_in = 12'h300; csr_op_in = 3'b001; rs1_in = 32'h8; csr_wr_en_in = 1;
        step("rw_mstatus");
        check_val("mie_set_by_rw", {31'h0, mie_out}, 32'h1);
        csr_addr_in = 12'h300; csr_op_in = 3'b111; zimm_in = 5'h8; csr_wr_en_in = 1;
        #1;
        check_val("rc_read_old", csr_data_out, 32'h1808);
        step("rc_mstatus");
        check_val("mie_clr_by_rc", {31'h0, mie_out}, 32'h0);

        // Trap entry with a misaligned fault while MIE=1.
        csr_addr_in = 12'h300; csr_op_in = 3'b001; rs1_in = 32'h8; csr_wr_en_in = 1;
        step("mie_on");
        idle_inputs();
        pc_in = 32'h104; cause_in = 4'd4; i_or_e_in = 0;
        misaligned_exception_in = 1; fault_addr_in = 32'h203;
        set_epc_in = 1; set_cause_in = 1; mie_clear_in = 1;
        step("trap_entry");
        idle_inputs();
        peek(12'h341, "trap_mepc", 32'h104);
        peek(12'h342, "trap_mcause", 32'h4);
        peek(12'h343, "trap_mtval", 32'h203);
        peek(12'h300, "trap_mstatus", 32'h1880);

        // Vectored mode timer interrupt, then mret.
        csr_addr_in = 12'h305; csr_op_in = 3'b001; rs1_in = 32'h1001; csr_wr_en_in = 1;
        step("mtvec_wr");
        idle_inputs();
        set_cause_in = 1; i_or_e_in = 1; cause_in = 4'd7;
        step("timer_irq");
        idle_inputs();
        check_val("vec_trap_addr", trap_address_out, 32'h101C);
        mie_set_in = 1;
        step("mret");
        idle_inputs();
        peek(12'h300, "mret_mstatus", 32'h1888);
        check_val("mret_mie", {31'h0, mie_out}, 32'h1);

        // minstret low write with increment held: write wins, then carries.
        csr_addr_in = 12'hB02; csr_op_in = 3'b001; rs1_in = 32'hFFFF_FFFF;
        csr_wr_en_in = 1; instret_inc_in = 1;
        step("instret_wr");
        peek(12'hB02, "instret_lo_wr", 32'hFFFF_FFFF);
        step("instret_inc");
        peek(12'hB02, "instret_lo_wrap", 32'h0);
        peek(12'hB82, "instret_hi_carry", 32'h1);
        idle_inputs();

        // Hardware cause update beats a same-cycle software write.
        csr_addr_in = 12'h342; csr_op_in = 3'b001; rs1_in = 32'h5; csr_wr_en_in = 1;
        set_cause_in = 1; cause_in = 4'd2; i_or_e_in = 0;
        step("cause_prio");
        idle_inputs();
        peek(12'h342, "cause_prio_val", 32'h2);

        repeat (300) random_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
